vram_wr_queue: RTL and testbench
================================

Name: vram_wr_queue

Overview:
- Producer for the video block's CPU write port; feeds its vaddr/md/wr/double_cas inputs.
- Accepts CPU-side VRAM writes at any cycle and buffers them in a small FIFO.
- Presents the head entry until the video fetch unit consumes it in its WR_CPU memory slot, which occurs once per 6-cycle phase rotation.
- Applies the "write to Spectrum screen off" filter before queueing.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 20, address width.
- DW, 16, data width.

Ports:
- clk42_i  in  1  system clock, 42 MHz
- res_n_i  in  1  reset, asynchronous, active-low
- cpu_addr_i  in  20  write address; bit19=1 graphics linear, bit19=0 Spectrum-mode
- cpu_data_i  in  16  write data
- cpu_word_i  in  1  16-bit (double CAS) write when 1, else byte
- cpu_wr_i  in  1  one-cycle write request strobe
- scr_wr_off_i  in  1  drop Spectrum-mode writes when 1 (dir_port bit2)
- cpu_full_o  out  1  FIFO full
- vaddr_o  out  20  to video vaddr_i
- md_o  out  16  to video md_i
- wr_o  out  1  head entry valid, to video wr_i
- double_cas_o  out  1  to video double_cas_i
- slot_i  in  1  one-cycle strobe: WR_CPU slot consumes presented entry this cycle
- ovf_o  out  1  sticky: a write was lost to overflow
- ovf_clr_i  in  1  clears ovf_o
- level_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync-released state use): FIFO empty, state IDLE, wr_o=0, vaddr_o=0, md_o=0, double_cas_o=0, ovf_o=0, cpu_full_o=0, level_o=0. In-flight entries are discarded.
- Push accept: cpu_wr_i & !filtered & (!full | pop_this_cycle).
- Filter: filtered = scr_wr_off_i & ~cpu_addr_i[19]. Filtered writes are silently dropped and do not set ovf_o.
- Entry format: {cpu_word_i, cpu_addr_i, cpu_data_i}, 37 bits, stored unmodified. Address translation is done downstream.
- Pop: slot_i & wr_o. The entry presented in that cycle is committed.
  - slot_i while wr_o=0 is ignored.
  - slot_i is sampled only in PRESENT state.
- State machine:
  - IDLE: wr_o=0. On push, go to PRESENT next cycle with the pushed entry on outputs. Latency from cpu_wr_i to wr_o is 1 cycle.
  - PRESENT: wr_o=1; outputs are registered from the FIFO head and stable until pop.
    - On pop with level>1: stay in PRESENT; the next entry appears the following cycle.
    - On pop with level==1 and no simultaneous push: go to IDLE.
    - On pop with simultaneous push into an otherwise empty FIFO: stay in PRESENT with the new entry.
- Outputs never change while wr_o=1 and no pop has occurred. The video block may sample at any cycle.
- Full:
  - cpu_full_o = (level==DEPTH).
  - Push while full and no same-cycle pop: write dropped, ovf_o<=1.
  - Push while full with same-cycle pop: accepted, level unchanged.
- Sticky overflow: if ovf_clr_i and an overflow event occur in the same cycle, set wins (ovf_o=1).
- Ordering: strict FIFO, no coalescing or reordering.
- Pointers: wrap modulo DEPTH. level_o counts 0..DEPTH; it increments on push-only, decrements on pop-only, and holds on both or neither.
- Throughput: at most one pop per slot, 1 per 6 clk42 cycles. The CPU may burst up to DEPTH writes back-to-back.

Decomposition:
- Shared package vram_pkg:
  - VRAM_AW=20, VRAM_DW=16
  - typedef vram_wr_t = struct {logic word; logic [19:0] addr; logic [15:0] data;}
  - WR_SLOT_PERIOD=6
- Sub-module: vram_wr_fifo. Synchronous FIFO with registered head output, push/pop, full/empty/level.
- vram_wr_queue adds the filter, overflow flag and presentation FSM.

Test Plan:
- Single write:
  - Stimulus: reset, then cpu_wr_i with addr=20'h8_1234, data=16'hBEEF, word=1.
  - Required: next cycle wr_o=1, vaddr_o=20'h81234, md_o=BEEF, double_cas_o=1, held until slot_i. Cycle after slot: wr_o=0, level_o=0.
- Burst:
  - Stimulus: 4 back-to-back writes, data 1..4, slot_i every 6 cycles.
  - Required: md_o shows 1,2,3,4 in order. cpu_full_o=1 after the 4th push. wr_o drops one cycle after the 4th slot.
- Overflow:
  - Stimulus: fill 4 entries, 5th write without slot.
  - Required: 5th write lost, ovf_o=1, level_o=4.
  - Then: ovf_clr_i clears ovf_o. 5th write issued coincident with slot_i is accepted and level stays 4.
- Filter:
  - Stimulus: scr_wr_off_i=1, write addr=20'h0_4000, then write addr=20'h8_4000.
  - Required: only the 8_4000 entry is queued, ovf_o stays 0.
- Reset mid-operation:
  - Stimulus: 3 entries queued, res_n_i low for 1 cycle between slots.
  - Required: wr_o=0 immediately (asynchronous), level_o=0, ovf_o=0. Subsequent slot_i pulses cause no pops.
- Spurious slot:
  - Stimulus: slot_i pulses while IDLE, then a write arrives on the same cycle as slot_i.
  - Required: no underflow, level_o=1, wr_o=1 next cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM CPU-write path.
// An entry is stored unmodified; address translation happens downstream.
package vram_pkg;

    localparam int VRAM_AW        = 20;
    localparam int VRAM_DW        = 16;
    localparam int WR_SLOT_PERIOD = 6;

    typedef struct packed {
        logic               word;
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] data;
    } vram_wr_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } wr_state_e;

    // Spectrum-mode writes (addr bit19 clear) are discarded while the screen is off.
    function automatic logic is_filtered(input logic scr_off, input logic [VRAM_AW-1:0] addr);
        return scr_off & ~addr[VRAM_AW-1];
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so the consumer
// sees a glitch-free value that only moves on a pop.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  vram_wr_t               i_data,
    output vram_wr_t               o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PW = $clog2(DEPTH);

    vram_wr_t          r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_level;
    vram_wr_t          r_head;
    vram_wr_t          w_head_next;
    logic [PW-1:0]     w_rd_ptr_inc;

    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

    // A pop of the last entry with a coincident push bypasses storage.
    always_comb begin
        w_head_next = r_head;
        if (i_pop) begin
            if (r_level != (PW+1)'(1)) begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end else if (i_push) begin
                w_head_next = i_data;
            end
        end else if (i_push && (r_level == '0)) begin
            w_head_next = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            r_head <= w_head_next;
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + (PW+1)'(1);
                2'b01:   r_level <= r_level - (PW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_level = r_level;
    assign o_full  = (r_level == (PW+1)'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/vram_wr_queue.sv
// CPU-side VRAM write queue feeding the video block's WR_CPU slot: filters
// screen-off Spectrum writes, buffers the rest and presents the head entry.
module vram_wr_queue
    import vram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = VRAM_AW,
    parameter int DW    = VRAM_DW
) (
    input  logic                   clk42_i,
    input  logic                   res_n_i,
    input  logic [AW-1:0]          cpu_addr_i,
    input  logic [DW-1:0]          cpu_data_i,
    input  logic                   cpu_word_i,
    input  logic                   cpu_wr_i,
    input  logic                   scr_wr_off_i,
    output logic                   cpu_full_o,
    output logic [AW-1:0]          vaddr_o,
    output logic [DW-1:0]          md_o,
    output logic                   wr_o,
    output logic                   double_cas_o,
    input  logic                   slot_i,
    output logic                   ovf_o,
    input  logic                   ovf_clr_i,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    wr_state_e   r_state;
    wr_state_e   w_state_next;
    logic        r_ovf;
    logic        w_filtered;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_evt;
    logic        w_full;
    logic        w_empty;
    logic [LW-1:0] w_level;
    vram_wr_t    w_entry;
    vram_wr_t    w_head;

    assign w_entry    = {cpu_word_i, cpu_addr_i, cpu_data_i};
    assign w_filtered = is_filtered(scr_wr_off_i, cpu_addr_i);
    assign w_pop      = slot_i & (r_state == ST_PRESENT);
    // A full queue still accepts a write when the slot frees an entry in the same cycle.
    assign w_push     = cpu_wr_i & ~w_filtered & (~w_full | w_pop);
    assign w_ovf_evt  = cpu_wr_i & ~w_filtered & w_full & ~w_pop;

    vram_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk42_i),
        .i_rst_n (res_n_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (w_pop && (w_level == LW'(1)) && !w_push) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk42_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign wr_o         = (r_state == ST_PRESENT);
    assign vaddr_o      = w_head.addr;
    assign md_o         = w_head.data;
    assign double_cas_o = w_head.word;
    assign cpu_full_o   = w_full;
    assign ovf_o        = r_ovf;
    assign level_o      = w_level;

    logic w_unused;
    assign w_unused = w_empty;

endmodule

// File: tb/tb_vram_wr_queue.sv
// Directed bench for vram_wr_queue: each scenario task drives its vectors
// and compares against hand-computed values.
module tb_vram_wr_queue;

    logic        clk42_i = 1'b0;
    logic        res_n_i;
    logic [19:0] cpu_addr_i;
    logic [15:0] cpu_data_i;
    logic        cpu_word_i;
    logic        cpu_wr_i;
    logic        scr_wr_off_i;
    logic        cpu_full_o;
    logic [19:0] vaddr_o;
    logic [15:0] md_o;
    logic        wr_o;
    logic        double_cas_o;
    logic        slot_i;
    logic        ovf_o;
    logic        ovf_clr_i;
    logic [2:0]  level_o;

    int vectors     = 0;
    int miscompares = 0;

    vram_wr_queue #(.DEPTH(4), .AW(20), .DW(16)) dut (
        .clk42_i      (clk42_i),
        .res_n_i      (res_n_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_word_i   (cpu_word_i),
        .cpu_wr_i     (cpu_wr_i),
        .scr_wr_off_i (scr_wr_off_i),
        .cpu_full_o   (cpu_full_o),
        .vaddr_o      (vaddr_o),
        .md_o         (md_o),
        .wr_o         (wr_o),
        .double_cas_o (double_cas_o),
        .slot_i       (slot_i),
        .ovf_o        (ovf_o),
        .ovf_clr_i    (ovf_clr_i),
        .level_o      (level_o)
    );

    always #5 clk42_i = ~clk42_i;

    task automatic step();
        @(posedge clk42_i);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_wr_i   = 1'b0;
        slot_i     = 1'b0;
        ovf_clr_i  = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        cpu_word_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        scr_wr_off_i = 1'b0;
        res_n_i = 1'b0;
        step();
        step();
        res_n_i = 1'b1;
        step();
    endtask

    task automatic push(input logic [19:0] a, input logic [15:0] d, input logic w);
        cpu_wr_i   = 1'b1;
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_word_i = w;
        step();
        cpu_wr_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [42:0] got;
        logic [42:0] exp;
        do_reset();
        got = {wr_o, vaddr_o, md_o, double_cas_o, level_o, cpu_full_o, ovf_o};
        exp = '0;
        vectors++;
        if (got !== exp) begin
            $display("FAIL reset_state: got %h expected %h", got, exp);
            miscompares++;
        end
    endtask

    task automatic test_single_write();
        logic [42:0] got;
        logic [42:0] exp;
        logic [3:0]  got_s;
        do_reset();
        push(20'h8_1234, 16'hBEEF, 1'b1);
        exp = {1'b1, 20'h81234, 16'hBEEF, 1'b1, 3'd1, 1'b0, 1'b0};
        got = {wr_o, vaddr_o, md_o, double_cas_o, level_o, cpu_full_o, ovf_o};
        vectors++;
        if (got !== exp) begin
            $display("FAIL single_present: got %h expected %h", got, exp);
            miscompares++;
        end
        repeat (5) step();
        got = {wr_o, vaddr_o, md_o, double_cas_o, level_o, cpu_full_o, ovf_o};
        vectors++;
        if (got !== exp) begin
            $display("FAIL single_hold: got %h expected %h", got, exp);
            miscompares++;
        end
        slot_i = 1'b1;
        step();
        slot_i = 1'b0;
        got_s = {wr_o, level_o};
        vectors++;
        if (got_s !== 4'b0_000) begin
            $display("FAIL single_after_slot: got wr/level %b expected 0000", got_s);
            miscompares++;
        end
    endtask

    task automatic test_burst();
        logic [20:0] got;
        logic [20:0] exp;
        logic [16:0] got_p;
        logic [3:0]  got_s;
        logic [3:0]  exp_s;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push(20'(20'h8_0000 + i), 16'(i), 1'b0);
        end
        got = {cpu_full_o, level_o, md_o, wr_o};
        exp = {1'b1, 3'd4, 16'd1, 1'b1};
        vectors++;
        if (got !== exp) begin
            $display("FAIL burst_full: got %h expected %h", got, exp);
            miscompares++;
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (5) step();
            got_p = {wr_o, md_o};
            vectors++;
            if (got_p !== {1'b1, 16'(k)}) begin
                $display("FAIL burst_before_slot%0d: got wr/md %h expected %h", k, got_p, {1'b1, 16'(k)});
                miscompares++;
            end
            slot_i = 1'b1;
            step();
            slot_i = 1'b0;
            got_s = {wr_o, level_o};
            exp_s = {(k < 4), 3'(4 - k)};
            vectors++;
            if (got_s !== exp_s) begin
                $display("FAIL burst_after_slot%0d: got wr/level %b expected %b", k, got_s, exp_s);
                miscompares++;
            end
            if (k < 4) begin
                vectors++;
                if (md_o !== 16'(k + 1)) begin
                    $display("FAIL burst_next%0d: got md %h expected %h", k, md_o, 16'(k + 1));
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [20:0] got;
        logic [20:0] exp;
        logic [15:0] drain_exp [3];
        logic [18:0] got_d;
        logic [3:0]  got_s;
        drain_exp = '{16'h0012, 16'h0013, 16'h0015};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(20'(20'h8_0100 + i), 16'(16'h0010 + i), 1'b0);
        end
        push(20'h8_0200, 16'h0014, 1'b0);
        got = {ovf_o, level_o, cpu_full_o, md_o};
        exp = {1'b1, 3'd4, 1'b1, 16'h0010};
        vectors++;
        if (got !== exp) begin
            $display("FAIL ovf_set: got %h expected %h", got, exp);
            miscompares++;
        end
        cpu_wr_i   = 1'b1;
        cpu_addr_i = 20'h8_0201;
        cpu_data_i = 16'h0016;
        ovf_clr_i  = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if ({ovf_o, level_o} !== {1'b1, 3'd4}) begin
            $display("FAIL ovf_set_wins: got ovf/level %b expected 1100", {ovf_o, level_o});
            miscompares++;
        end
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        vectors++;
        if (ovf_o !== 1'b0) begin
            $display("FAIL ovf_clear: got %b expected 0", ovf_o);
            miscompares++;
        end
        cpu_wr_i   = 1'b1;
        cpu_addr_i = 20'h8_0202;
        cpu_data_i = 16'h0015;
        slot_i     = 1'b1;
        step();
        idle_inputs();
        got = {ovf_o, level_o, cpu_full_o, md_o};
        exp = {1'b0, 3'd4, 1'b1, 16'h0011};
        vectors++;
        if (got !== exp) begin
            $display("FAIL ovf_push_pop: got %h expected %h", got, exp);
            miscompares++;
        end
        for (int j = 0; j < 3; j++) begin
            slot_i = 1'b1;
            step();
            slot_i = 1'b0;
            got_d = {level_o, md_o};
            vectors++;
            if (got_d !== {3'(3 - j), drain_exp[j]}) begin
                $display("FAIL ovf_drain%0d: got level/md %h expected %h", j, got_d, {3'(3 - j), drain_exp[j]});
                miscompares++;
            end
        end
        slot_i = 1'b1;
        step();
        slot_i = 1'b0;
        got_s = {wr_o, level_o};
        vectors++;
        if (got_s !== 4'b0_000) begin
            $display("FAIL ovf_drained: got wr/level %b expected 0000", got_s);
            miscompares++;
        end
    endtask

    task automatic test_filter();
        logic [4:0]  got_s;
        logic [41:0] got;
        logic [41:0] exp;
        do_reset();
        scr_wr_off_i = 1'b1;
        push(20'h0_4000, 16'hAAAA, 1'b0);
        got_s = {wr_o, level_o, ovf_o};
        vectors++;
        if (got_s !== 5'b0) begin
            $display("FAIL filter_drop: got wr/level/ovf %b expected 00000", got_s);
            miscompares++;
        end
        push(20'h8_4000, 16'h5555, 1'b1);
        got = {wr_o, vaddr_o, md_o, double_cas_o, level_o, ovf_o};
        exp = {1'b1, 20'h84000, 16'h5555, 1'b1, 3'd1, 1'b0};
        vectors++;
        if (got !== exp) begin
            $display("FAIL filter_pass: got %h expected %h", got, exp);
            miscompares++;
        end
        for (int i = 1; i <= 3; i++) begin
            push(20'(20'h8_4000 + i), 16'(16'h5555 + i), 1'b0);
        end
        push(20'h0_4001, 16'hAAAB, 1'b0);
        vectors++;
        if ({level_o, ovf_o, md_o} !== {3'd4, 1'b0, 16'h5555}) begin
            $display("FAIL filter_full_no_ovf: got level/ovf/md %h expected %h", {level_o, ovf_o, md_o}, {3'd4, 1'b0, 16'h5555});
            miscompares++;
        end
        do_reset();
        push(20'h0_4000, 16'hAAAA, 1'b0);
        vectors++;
        if ({wr_o, vaddr_o, level_o} !== {1'b1, 20'h04000, 3'd1}) begin
            $display("FAIL filter_off_pass: got wr/vaddr/level %h expected %h", {wr_o, vaddr_o, level_o}, {1'b1, 20'h04000, 3'd1});
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got_s;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(20'(20'h8_0300 + i), 16'(16'h0300 + i), 1'b0);
        end
        step();
        step();
        #2;
        res_n_i = 1'b0;
        #1;
        got_s = {wr_o, level_o, ovf_o, cpu_full_o};
        vectors++;
        if (got_s !== 6'b0) begin
            $display("FAIL reset_async: got wr/level/ovf/full %b expected 000000", got_s);
            miscompares++;
        end
        step();
        res_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slot_i = 1'b1;
            step();
            slot_i = 1'b0;
            vectors++;
            if ({wr_o, level_o} !== 4'b0) begin
                $display("FAIL reset_no_pop%0d: got wr/level %b expected 0000", i, {wr_o, level_o});
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] got;
        do_reset();
        slot_i = 1'b1;
        repeat (3) step();
        vectors++;
        if ({wr_o, level_o} !== 4'b0) begin
            $display("FAIL spurious_idle: got wr/level %b expected 0000", {wr_o, level_o});
            miscompares++;
        end
        cpu_wr_i   = 1'b1;
        cpu_addr_i = 20'h8_0C01;
        cpu_data_i = 16'hC001;
        step();
        idle_inputs();
        got = {wr_o, level_o, md_o};
        vectors++;
        if (got !== {1'b1, 3'd1, 16'hC001}) begin
            $display("FAIL spurious_push: got %h expected %h", got, {1'b1, 3'd1, 16'hC001});
            miscompares++;
        end
        cpu_wr_i   = 1'b1;
        cpu_addr_i = 20'h8_0C02;
        cpu_data_i = 16'hC002;
        slot_i     = 1'b1;
        step();
        idle_inputs();
        got = {wr_o, level_o, md_o};
        vectors++;
        if (got !== {1'b1, 3'd1, 16'hC002}) begin
            $display("FAIL pop_push_level1: got %h expected %h", got, {1'b1, 3'd1, 16'hC002});
            miscompares++;
        end
        slot_i = 1'b1;
        step();
        slot_i = 1'b0;
        vectors++;
        if ({wr_o, level_o} !== 4'b0) begin
            $display("FAIL b2b_empty: got wr/level %b expected 0000", {wr_o, level_o});
            miscompares++;
        end
    endtask

    initial begin
        res_n_i      = 1'b0;
        scr_wr_off_i = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_burst();
        test_overflow();
        test_filter();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
